// File: rtl/uart_loader_pkg.sv
// Shared definitions for the UART program loader: state encoding and default memory depth.
package uart_loader_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 10;

  typedef logic [2:0] loader_state_t;

  localparam loader_state_t HDR   = 3'd0;
  localparam loader_state_t LOAD  = 3'd1;
  localparam loader_state_t CSUM  = 3'd2;
  localparam loader_state_t DONE  = 3'd3;
  localparam loader_state_t ERROR = 3'd4;

endpackage

// File: rtl/uart_prog_loader_if.sv
// Word stream from the UART assembler and instruction-memory write port of the program loader.
interface uart_prog_loader_if
  import uart_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);

  logic [31:0]           data_in;
  logic                  data_valid;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;

  modport master (
    output data_in,
    output data_valid,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

  modport slave (
    input  data_in,
    input  data_valid,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

endinterface

// File: rtl/loader_csum.sv
// 32-bit wrapping accumulator with synchronous clear and add-enable.
module loader_csum (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        add_en,
  input  logic [31:0] add_value,
  output logic [31:0] sum
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum <= '0;
    end else if (clear) begin
      sum <= '0;
    end else if (add_en) begin
      sum <= sum + add_value;
    end
  end

endmodule

// File: rtl/uart_prog_loader.sv
// Loads a length-prefixed word stream into instruction memory and holds the core until done.
// Optional trailing checksum word is compiled in with LOADER_CHECKSUM_EN.
module uart_prog_loader
  import uart_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  uart_prog_loader_if.slave   bus,
  input  logic                rearm,
  output logic                cpu_hold,
  output logic                load_done,
  output logic                load_error
);

  localparam logic [31:0] MAX_WORDS = 32'(1) << ADDR_WIDTH;

  loader_state_t         state;
  logic [ADDR_WIDTH:0]   counter;
  logic [ADDR_WIDTH:0]   remaining;
  logic                  header_ok;

  assign header_ok = (bus.data_in != 32'd0) && (bus.data_in <= MAX_WORDS);

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] sum;
  logic        sum_clear;
  logic        sum_add;

  assign sum_clear = (state == HDR) && bus.data_valid && header_ok;
  assign sum_add   = (state == LOAD) && bus.data_valid;

  loader_csum u_csum (
    .clk       (clk),
    .reset     (reset),
    .clear     (sum_clear),
    .add_en    (sum_add),
    .add_value (bus.data_in),
    .sum       (sum)
  );
`endif

  // Counter is one bit wider than the address so a full-depth load ends on the last address.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= HDR;
      counter       <= '0;
      remaining     <= '0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      cpu_hold      <= 1'b1;
      load_done     <= 1'b0;
      load_error    <= 1'b0;
    end else begin
      bus.mem_we <= 1'b0;
      case (state)
        HDR: begin
          if (bus.data_valid) begin
            if (header_ok) begin
              remaining <= bus.data_in[ADDR_WIDTH:0];
              counter   <= '0;
              state     <= LOAD;
            end else begin
              load_error <= 1'b1;
              state      <= ERROR;
            end
          end
        end
        LOAD: begin
          if (bus.data_valid) begin
            bus.mem_we    <= 1'b1;
            bus.mem_addr  <= counter[ADDR_WIDTH-1:0];
            bus.mem_wdata <= bus.data_in;
            counter       <= counter + 1'b1;
            remaining     <= remaining - 1'b1;
            if (remaining == 1) begin
`ifdef LOADER_CHECKSUM_EN
              state <= CSUM;
`else
              state     <= DONE;
              load_done <= 1'b1;
              cpu_hold  <= 1'b0;
`endif
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CSUM: begin
          if (bus.data_valid) begin
            if (bus.data_in == sum) begin
              state     <= DONE;
              load_done <= 1'b1;
              cpu_hold  <= 1'b0;
            end else begin
              state      <= ERROR;
              load_error <= 1'b1;
            end
          end
        end
`endif
        DONE, ERROR: begin
          if (rearm) begin
            state      <= HDR;
            load_done  <= 1'b0;
            load_error <= 1'b0;
            cpu_hold   <= 1'b1;
          end
        end
        default: begin
          state <= HDR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Scoreboard bench for uart_prog_loader; follows LOADER_CHECKSUM_EN to send checksum words.
module tb_uart_prog_loader;
  import uart_loader_pkg::*;

  localparam int AW = DEFAULT_ADDR_WIDTH;
  localparam int MAX_WORDS = 1 << AW;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  logic clk;
  logic reset;
  logic rearm;
  logic cpu_hold;
  logic load_done;
  logic load_error;

  int total;
  int bad;
  int last_addr;
  wr_t exp_q[$];

  uart_prog_loader_if #(.ADDR_WIDTH(AW)) bus ();

  uart_prog_loader #(.ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .rearm      (rearm),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_error (load_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired: got timeout, required completion");
    $fatal(1, "[TB] watchdog");
  end

  // Monitor: every write pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (reset && bus.mem_we) begin
      total = total + 1;
      if (exp_q.size() == 0) begin
        bad = bad + 1;
        $display("[TB] FAIL unexpected_write: got addr=%0d data=%h, required no write",
                 bus.mem_addr, bus.mem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (bus.mem_addr !== e.addr || bus.mem_wdata !== e.data) begin
          bad = bad + 1;
          $display("[TB] FAIL write: got addr=%0d data=%h, required addr=%0d data=%h",
                   bus.mem_addr, bus.mem_wdata, e.addr, e.data);
        end
        last_addr = int'(bus.mem_addr);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total = total + 1;
    if (actual !== expected) begin
      bad = bad + 1;
      $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
    end
  endtask

  task automatic checkStatus(input string name, input logic hold, input logic done,
                             input logic err);
    checkOutput({name, ".cpu_hold"}, 32'(cpu_hold), 32'(hold));
    checkOutput({name, ".load_done"}, 32'(load_done), 32'(done));
    checkOutput({name, ".load_error"}, 32'(load_error), 32'(err));
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] w, input logic rearm_bit);
    @(negedge clk);
    bus.data_valid = valid;
    bus.data_in    = w;
    rearm          = rearm_bit;
  endtask

  task automatic idle();
    @(negedge clk);
    bus.data_valid = 1'b0;
    bus.data_in    = 32'd0;
    rearm          = 1'b0;
  endtask

  task automatic dataWord(input logic [31:0] w, input int addr);
    wr_t e;
    e.addr = AW'(addr);
    e.data = w;
    exp_q.push_back(e);
    applyStimulus(1'b1, w, 1'b0);
  endtask

  task automatic checkDrained(input string name);
    repeat (2) @(negedge clk);
    checkOutput(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic doRearm();
    applyStimulus(1'b0, 32'd0, 1'b1);
    idle();
    checkStatus("rearm", 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] sum;
    total          = 0;
    bad            = 0;
    last_addr      = -1;
    reset          = 1'b0;
    rearm          = 1'b0;
    bus.data_valid = 1'b0;
    bus.data_in    = 32'd0;

    repeat (3) @(negedge clk);
    checkStatus("reset", 1'b1, 1'b0, 1'b0);
    checkOutput("reset.mem_we", 32'(bus.mem_we), 32'd0);
    reset = 1'b1;

    $display("[TB] nominal load");
    applyStimulus(1'b1, 32'd3, 1'b0);
    dataWord(32'h00000013, 0);
    dataWord(32'h00100093, 1);
    dataWord(32'hFFFFFFFF, 2);
`ifdef LOADER_CHECKSUM_EN
    applyStimulus(1'b1, 32'h001000A5, 1'b0);
`endif
    idle();
    checkStatus("nominal", 1'b0, 1'b1, 1'b0);
    checkDrained("nominal.drained");

    applyStimulus(1'b1, 32'h12345678, 1'b0);
    idle();
    checkStatus("done_ignores_data", 1'b0, 1'b1, 1'b0);
    doRearm();

`ifdef LOADER_CHECKSUM_EN
    $display("[TB] bad checksum");
    applyStimulus(1'b1, 32'd3, 1'b0);
    dataWord(32'h00000013, 0);
    dataWord(32'h00100093, 1);
    dataWord(32'hFFFFFFFF, 2);
    applyStimulus(1'b1, 32'h00000000, 1'b0);
    idle();
    checkStatus("bad_csum", 1'b1, 1'b0, 1'b1);
    checkDrained("bad_csum.drained");
    doRearm();
`endif

    $display("[TB] invalid headers");
    applyStimulus(1'b1, 32'd0, 1'b0);
    idle();
    checkStatus("hdr_zero", 1'b1, 1'b0, 1'b1);
    doRearm();
    applyStimulus(1'b1, 32'(MAX_WORDS + 1), 1'b0);
    idle();
    checkStatus("hdr_too_big", 1'b1, 1'b0, 1'b1);
    doRearm();

    $display("[TB] full depth back-to-back");
    sum = 32'd0;
    applyStimulus(1'b1, 32'(MAX_WORDS), 1'b0);
    for (int i = 0; i < MAX_WORDS; i++) begin
      dataWord(32'h10000000 + 32'(i), i);
      sum = sum + 32'h10000000 + 32'(i);
    end
`ifdef LOADER_CHECKSUM_EN
    applyStimulus(1'b1, sum, 1'b0);
`endif
    idle();
    checkStatus("full_depth", 1'b0, 1'b1, 1'b0);
    checkDrained("full_depth.drained");
    checkOutput("full_depth.last_addr", 32'(last_addr), 32'(MAX_WORDS - 1));

    $display("[TB] rearm with simultaneous data");
    applyStimulus(1'b1, 32'hDEADBEEF, 1'b1);
    idle();
    checkStatus("rearm_with_data", 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'd1, 1'b0);
    dataWord(32'hCAFE0001, 0);
`ifdef LOADER_CHECKSUM_EN
    applyStimulus(1'b1, 32'hCAFE0001, 1'b0);
`endif
    idle();
    checkStatus("after_rearm", 1'b0, 1'b1, 1'b0);
    checkDrained("after_rearm.drained");
    doRearm();

    $display("[TB] reset mid-load");
    applyStimulus(1'b1, 32'd5, 1'b0);
    dataWord(32'h0000AAAA, 0);
    dataWord(32'h0000BBBB, 1);
    idle();
    checkDrained("midload.drained");
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkStatus("midload_reset", 1'b1, 1'b0, 1'b0);
    checkOutput("midload_reset.mem_we", 32'(bus.mem_we), 32'd0);
    checkOutput("midload_reset.mem_addr", 32'(bus.mem_addr), 32'd0);
    checkOutput("midload_reset.mem_wdata", bus.mem_wdata, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(1'b1, 32'd1, 1'b0);
    dataWord(32'h00000077, 0);
`ifdef LOADER_CHECKSUM_EN
    applyStimulus(1'b1, 32'h00000077, 1'b0);
`endif
    idle();
    checkStatus("after_reset_load", 1'b0, 1'b1, 1'b0);
    checkDrained("after_reset_load.drained");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_prog_loader.md
# uart_prog_loader

Word-stream program loader sitting directly downstream of the 32-bit UART word assembler. It consumes assembled 32-bit words, interprets the first as a length header, and writes the following words into instruction memory at consecutive addresses. An optional checksum word validates the transfer. The loader holds the RISC-V core in reset until a load completes successfully.

## Interface
- ADDR_WIDTH, 10, instruction-memory word-address width; maximum program length is 2**ADDR_WIDTH words.
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset; 0 = reset asserted.
- data_in  input  32  assembled word from the UART word assembler.
- data_valid  input  1  one-cycle strobe; data_in is valid in this cycle.
- rearm  input  1  one-cycle pulse; returns the loader from DONE or ERROR to HDR.
- mem_we  output  1  instruction-memory write enable, one-cycle pulse.
- mem_addr  output  ADDR_WIDTH  word address for the write.
- mem_wdata  output  32  write data.
- cpu_hold  output  1  1 = core held in reset.
- load_done  output  1  level; program loaded and accepted.
- load_error  output  1  level; header or checksum rejected.

## Operation
- States: HDR, LOAD, CSUM (only when checksum is compiled in), DONE, ERROR.
- HDR: wait for data_valid.
  - Take N = data_in.
  - If N == 0 or N > 2**ADDR_WIDTH, go to ERROR.
  - Otherwise latch remaining = N, clear the address counter and sum, and go to LOAD.
- LOAD: each data_valid does the following.
  - Registers mem_we = 1, mem_addr = counter and mem_wdata = data_in.
  - Increments the counter.
  - Sum += data_in, mod 2^32, wrapping.
  - Decrements remaining.
  - On the valid with remaining == 1: go to CSUM if checksum is compiled in, else to DONE.
- CSUM: on the next data_valid, if data_in == sum go to DONE, else go to ERROR. No memory write occurs in CSUM.
- DONE: load_done = 1 and cpu_hold = 0.
- ERROR: load_error = 1 and cpu_hold = 1.
- In DONE and ERROR, data_valid is ignored.
- rearm pulse in DONE or ERROR: go to HDR, clear load_done and load_error, and set cpu_hold = 1. rearm is ignored in all other states.
- The address counter is ADDR_WIDTH+1 bits internally. mem_addr is its low ADDR_WIDTH bits. With N = 2**ADDR_WIDTH, the last write goes to address 2**ADDR_WIDTH-1 with no wrap to 0 before it.
- Reset, including mid-load: state = HDR, counter = 0, sum = 0, and remaining = 0.
  - Outputs: mem_we = 0, mem_addr = 0, mem_wdata = 0, cpu_hold = 1, load_done = 0, load_error = 0.
  - Memory contents written before the reset are not cleared.

## Timing
- Write latency: mem_we, mem_addr and mem_wdata are registered. They appear in the cycle after the accepting data_valid edge, for exactly one cycle.
- Back-to-back data_valid on consecutive cycles must be accepted with no loss. There is no backpressure.
- State transitions take effect on the clock edge that samples data_valid or rearm.
- load_done, load_error and cpu_hold are registered. They change one cycle after the deciding data_valid or rearm edge.
- cpu_hold deasserts in the same cycle that load_done asserts. The final mem_we pulse occurs in that cycle or earlier.
- If rearm and data_valid are asserted together in DONE or ERROR, rearm wins and the word is discarded.

## Configuration
- Macro: LOADER_CHECKSUM_EN.
- Defined: the CSUM state exists. One extra word is expected after the N data words, and a mismatch goes to ERROR.
- Undefined: CSUM and the sum register are removed. The loader enters DONE after the Nth data word. ERROR is reachable only through an invalid header.

## Structure
- Shared package uart_loader_pkg contains:
  - the state encoding localparams: HDR, LOAD, CSUM, DONE, ERROR;
  - the default ADDR_WIDTH.
- One sub-module, loader_csum: a 32-bit wrapping accumulator with clear and add-enable.
  - Instantiated only under LOADER_CHECKSUM_EN.
  - Its output is compared in CSUM.

## Test plan
- Nominal load, checksum enabled: header 3, then 0x00000013, 0x00100093, 0xFFFFFFFF, then checksum 0x001000A5.
  - Expect three mem_we pulses at addresses 0, 1, 2 with matching data.
  - Expect load_done = 1 and cpu_hold falling to 0.
- Bad checksum: same words with checksum 0x00000000.
  - Expect three writes, then load_error = 1, cpu_hold = 1 and load_done = 0.
- Invalid headers:
  - header 0 gives ERROR with no mem_we;
  - header 2**ADDR_WIDTH+1 gives ERROR with no mem_we.
- Full depth, back-to-back: header 2**ADDR_WIDTH with consecutive-cycle valids.
  - Expect the last write at address 2**ADDR_WIDTH-1, no dropped words, and DONE.
- Reset mid-load: assert reset after 2 of 5 words.
  - Expect all outputs at reset values and state HDR.
  - A new header 1 plus its word (plus checksum) writes address 0 and reaches DONE.
- Rearm: from DONE, pulse rearm together with data_valid.
  - Expect the word ignored, cpu_hold = 1, load_done = 0, and the next word treated as a header.
